spm_seq: RTL

Parametrised sequential serial-parallel multiplier and the next generation of the `spm` carry-save array. It replaces the fixed 32-bit, free-running `spm` datapath with a WIDTH-generic core that runs as a start/done transaction. It adds a runtime signed/unsigned mode, valid/ready handshakes on both sides, and a parallel result register alongside the serial product stream. It sits where `spm` sits: fed by the operand staging logic, and read by the accumulator/writeback stage.

---
 rtl/spm_pkg.sv | 6 +
 rtl/spm_csa.sv | 34 +++
 rtl/spm_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/spm_pkg.sv
// Shared types and defaults for the serial-parallel multiplier.
package spm_pkg;
  localparam int SPM_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} spm_state_e;
endpackage

// File: rtl/spm_csa.sv
// One-bit carry-save cell: adds x&ys to the upstream sum and its own carry.
module spm_csa (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic init_i,
  input  logic x_i,
  input  logic ys_i,
  input  logic sin_i,
  output logic y
);
  logic       s_q, c_q, c_d;
  logic [1:0] t;

  // y is combinational from local flops only, so the chain never ripples
  always_comb begin
    t   = 2'(x_i & ys_i) + 2'(s_q) + 2'(c_q);
    c_d = t[1];
    y   = t[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (clr_i) begin
      s_q <= init_i;
      c_q <= init_i;
    end else begin
      s_q <= sin_i;
      c_q <= c_d;
    end
  end
endmodule

// File: rtl/spm_seq.sv
// WIDTH-generic start/done serial-parallel multiplier with signed/unsigned mode.
module spm_seq
  import spm_pkg::*;
#(
  parameter  int WIDTH = SPM_WIDTH_DEFAULT,
  localparam int PW    = 2 * WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic          tc,
  output logic          p_sbit,
  output logic          p_svalid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p
);
  localparam int KW = $clog2(PW) + 1;

  spm_state_e       state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] x_q, y_q, sum;
  logic             tc_q, accept;
  logic [PW-1:0]    p_q;

  assign accept = (state_q == IDLE) && in_valid;

  // Signed mode: x = x_u - x[W-1]*2^W. The negative row term is added as
  // ~(x[W-1]&yk) at weight 2^W per cycle plus a one-off 2^W bias, which the
  // MSB cell holds by loading both its sum and carry flops with 1 on accept.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic sin, init;
    if (i == WIDTH - 1) begin : g_msb
      assign sin  = tc_q & ~(x_q[WIDTH-1] & y_q[0]);
      assign init = tc;
    end else begin : g_mid
      assign sin  = sum[i+1];
      assign init = 1'b0;
    end
    spm_csa u_csa (
      .clk   (clk),
      .rst   (rst),
      .clr_i (accept),
      .init_i(init),
      .x_i   (x_q[i]),
      .ys_i  (y_q[0]),
      .sin_i (sin),
      .y     (sum[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      tc_q    <= 1'b0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          x_q     <= x;
          y_q     <= y;
          tc_q    <= tc;
          k_q     <= '0;
          state_q <= RUN;
        end
        RUN: begin
          p_q <= {sum[0], p_q[PW-1:1]};
          // arithmetic shift keeps feeding the sign bit once y is exhausted
          y_q <= {tc_q & y_q[WIDTH-1], y_q[WIDTH-1:1]};
          k_q <= k_q + 1'b1;
          if (k_q == KW'(PW - 1)) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p_svalid  = (state_q == RUN);
  assign p_sbit    = p_svalid & sum[0];
  assign p         = p_q;
endmodule
